// File: rtl/ibex_crc_unit_pkg.sv
// Shared types and constants for the iterative CRC32/CRC32C unit.
package ibex_crc_unit_pkg;

  typedef enum logic [5:0] {
    ALU_ADD      = 6'd0,
    ALU_SUB      = 6'd1,
    ALU_XOR      = 6'd2,
    ALU_OR       = 6'd3,
    ALU_AND      = 6'd4,
    ALU_CRC32_B  = 6'd56,
    ALU_CRC32_H  = 6'd57,
    ALU_CRC32_W  = 6'd58,
    ALU_CRC32C_B = 6'd59,
    ALU_CRC32C_H = 6'd60,
    ALU_CRC32C_W = 6'd61
  } alu_op_e;

  typedef enum logic [1:0] {
    CRC_IDLE,
    CRC_CALC,
    CRC_DONE
  } crc_state_e;

  localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC32C_POLY = 32'h82F63B78;

endpackage

// File: rtl/ibex_crc_unit_if.sv
// Issue/result handshake between ID and the CRC unit.
interface ibex_crc_unit_if;
  logic        valid_i;
  logic        ready_o;
  logic [5:0]  operator_i;
  logic [31:0] operand_a_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  modport master (
    output valid_i, operator_i, operand_a_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, operator_i, operand_a_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/ibex_crc_step.sv
// Combinational block applying Steps reflected-LFSR iterations to x.
module ibex_crc_step #(
  parameter int unsigned Steps = 1
) (
  input  logic [31:0] x,
  input  logic [31:0] poly,
  output logic [31:0] x_next
);

  always_comb begin
    x_next = x;
    for (int unsigned i = 0; i < Steps; i++) begin
      x_next = (x_next >> 1) ^ (poly & {32{x_next[0]}});
    end
  end

endmodule

// File: rtl/ibex_crc_unit.sv
// Iterative crc32[c].{b,h,w} executor: IDLE -> CALC -> DONE, BitsPerCycle steps per cycle.
module ibex_crc_unit
  import ibex_crc_unit_pkg::*;
#(
  parameter int unsigned BitsPerCycle = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  ibex_crc_unit_if.slave crc
);

  localparam int unsigned CntW = $clog2(32 / BitsPerCycle + 1);

  if (!(BitsPerCycle == 1 || BitsPerCycle == 2 ||
        BitsPerCycle == 4 || BitsPerCycle == 8)) begin : g_bad_bpc
    $fatal(1, "BitsPerCycle must be 1, 2, 4 or 8");
  end

  crc_state_e        state_q, state_d;
  logic [31:0]       x_q, x_d;
  logic [31:0]       poly_q, poly_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       x_step;

  logic              op_is_crc;
  logic [31:0]       op_poly;
  logic [CntW-1:0]   op_cnt;

  // Operator decode: polynomial and iteration count K = N / BitsPerCycle.
  always_comb begin
    op_is_crc = 1'b1;
    op_poly   = CRC32_POLY;
    op_cnt    = CntW'(32 / BitsPerCycle);
    case (crc.operator_i)
      ALU_CRC32_B:  op_cnt = CntW'(8 / BitsPerCycle);
      ALU_CRC32_H:  op_cnt = CntW'(16 / BitsPerCycle);
      ALU_CRC32_W:  op_cnt = CntW'(32 / BitsPerCycle);
      ALU_CRC32C_B: begin op_poly = CRC32C_POLY; op_cnt = CntW'(8 / BitsPerCycle);  end
      ALU_CRC32C_H: begin op_poly = CRC32C_POLY; op_cnt = CntW'(16 / BitsPerCycle); end
      ALU_CRC32C_W: begin op_poly = CRC32C_POLY; op_cnt = CntW'(32 / BitsPerCycle); end
      default:      op_is_crc = 1'b0;
    endcase
  end

  ibex_crc_step #(.Steps(BitsPerCycle)) u_step (
    .x      (x_q),
    .poly   (poly_q),
    .x_next (x_step)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CRC_IDLE;
      x_q     <= '0;
      poly_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      poly_q  <= poly_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    poly_d  = poly_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CRC_IDLE: begin
        if (crc.valid_i && !crc.kill_i && op_is_crc) begin
          x_d     = crc.operand_a_i;
          poly_d  = op_poly;
          cnt_d   = op_cnt;
          state_d = CRC_CALC;
        end
      end
      CRC_CALC: begin
        x_d   = x_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = CRC_DONE;
      end
      CRC_DONE: begin
        if (crc.ready_i) state_d = CRC_IDLE;
      end
      default: state_d = CRC_IDLE;
    endcase
    // A flush overrides everything, including a same-cycle issue.
    if (crc.kill_i) state_d = CRC_IDLE;
  end

  assign crc.ready_o  = (state_q == CRC_IDLE);
  assign crc.valid_o  = (state_q == CRC_DONE);
  assign crc.busy_o   = (state_q != CRC_IDLE);
  assign crc.result_o = (state_q == CRC_DONE) ? x_q : '0;

  a_valid_not_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    crc.valid_o |-> !crc.ready_o);

  a_result_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (crc.valid_o && !crc.ready_i && !crc.kill_i) |=> $stable(crc.result_o));

  a_cnt_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == CRC_CALC) |-> (cnt_q != '0));

endmodule
